// File: rtl/flog_pkg.sv
// Shared widths, IEEE-754 bfloat16 constants and FSM state type for the FLOG control stage.
package flog_pkg;

  localparam int unsigned FLOG_EXP_WIDTH   = 8;
  localparam int unsigned FLOG_FRACT_WIDTH = 7;
  localparam int unsigned FLOG_WIDTH       = 1 + FLOG_EXP_WIDTH + FLOG_FRACT_WIDTH;

  localparam logic [FLOG_WIDTH-1:0] QNAN      = 16'h7FC0;
  localparam logic [FLOG_WIDTH-1:0] PLUS_INF  = 16'h7F80;
  localparam logic [FLOG_WIDTH-1:0] MINUS_INF = 16'hFF80;
  localparam logic [FLOG_WIDTH-1:0] PLUS_ZERO = 16'h0000;
  localparam logic [FLOG_WIDTH-1:0] ONE       = 16'h3F80;

  typedef enum logic [2:0] {
    IDLE,
    DECIDE,
    START,
    WAIT,
    RESULT
  } flog_ctrl_state_t;

endpackage

// File: rtl/flog_special_ctrl_if.sv
// Operand, core and result handshakes of the FLOG control stage.
// slave: the control stage itself; master: whatever surrounds it (detector, core, consumer).
interface flog_special_ctrl_if #(
  parameter int unsigned EXP_WIDTH   = flog_pkg::FLOG_EXP_WIDTH,
  parameter int unsigned FRACT_WIDTH = flog_pkg::FLOG_FRACT_WIDTH
);

  localparam int unsigned OpWidth = 1 + EXP_WIDTH + FRACT_WIDTH;

  // Operand side
  logic                   valid_i;
  logic                   ready_o;
  logic                   s_op_i;
  logic [EXP_WIDTH-1:0]   exp_op_i;
  logic [FRACT_WIDTH-1:0] fract_op_i;
  logic                   isNaN_i;
  logic                   isSNaN_i;
  logic                   isInf_i;
  logic                   isZero_i;

  // Log core side
  logic                   core_start_o;
  logic [OpWidth-1:0]     core_op_o;
  logic                   core_done_i;
  logic [OpWidth-1:0]     core_res_i;
  logic                   core_inexact_i;

  // Result side
  logic                   valid_o;
  logic                   ready_i;
  logic [OpWidth-1:0]     res_o;
  logic                   invalid_o;
  logic                   divzero_o;
  logic                   inexact_o;
  logic                   busy_o;

  modport slave (
    input  valid_i, s_op_i, exp_op_i, fract_op_i, isNaN_i, isSNaN_i, isInf_i, isZero_i,
    input  core_done_i, core_res_i, core_inexact_i, ready_i,
    output ready_o, core_start_o, core_op_o, valid_o, res_o, invalid_o, divzero_o,
    output inexact_o, busy_o
  );

  modport master (
    output valid_i, s_op_i, exp_op_i, fract_op_i, isNaN_i, isSNaN_i, isInf_i, isZero_i,
    output core_done_i, core_res_i, core_inexact_i, ready_i,
    input  ready_o, core_start_o, core_op_o, valid_o, res_o, invalid_o, divzero_o,
    input  inexact_o, busy_o
  );

endinterface

// File: rtl/flog_special_mux.sv
// Priority table resolving special log operands without the arithmetic core.
module flog_special_mux
  import flog_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = FLOG_EXP_WIDTH,
  parameter int unsigned FRACT_WIDTH = FLOG_FRACT_WIDTH,
  localparam int unsigned OpWidth    = 1 + EXP_WIDTH + FRACT_WIDTH
) (
  input  logic [OpWidth-1:0] op_i,
  input  logic               is_nan_i,
  input  logic               is_snan_i,
  input  logic               is_inf_i,
  input  logic               is_zero_i,
  output logic               is_special_o,
  output logic [OpWidth-1:0] special_res_o,
  output logic               special_invalid_o,
  output logic               special_divzero_o
);

  logic                 sign;
  logic [EXP_WIDTH-1:0] exponent;

  assign sign     = op_i[OpWidth-1];
  assign exponent = op_i[OpWidth-2 -: EXP_WIDTH];

  // First matching rule wins; subnormals count as zero and the sign of a zero is ignored.
  always_comb begin
    is_special_o      = 1'b1;
    special_res_o     = QNAN;
    special_invalid_o = 1'b0;
    special_divzero_o = 1'b0;
    if (is_nan_i) begin
      special_invalid_o = is_snan_i;
    end else if (is_zero_i || (exponent == '0)) begin
      special_res_o     = MINUS_INF;
      special_divzero_o = 1'b1;
    end else if (sign) begin
      special_invalid_o = 1'b1;
    end else if (is_inf_i) begin
      special_res_o = PLUS_INF;
    end else if (op_i == ONE) begin
      special_res_o = PLUS_ZERO;
    end else begin
      is_special_o  = 1'b0;
      special_res_o = PLUS_ZERO;
    end
  end

endmodule

// File: rtl/flog_special_ctrl.sv
// FLOG control stage: resolves special operands locally, hands normal operands to the
// iterative log core, and presents one result with exception flags per accepted operand.
module flog_special_ctrl
  import flog_pkg::*;
#(
  parameter int unsigned EXP_WIDTH   = FLOG_EXP_WIDTH,
  parameter int unsigned FRACT_WIDTH = FLOG_FRACT_WIDTH
) (
  input logic                clk_i,
  input logic                rst_n_i,
  flog_special_ctrl_if.slave bus
);

  localparam int unsigned OpWidth = 1 + EXP_WIDTH + FRACT_WIDTH;

  flog_ctrl_state_t state_q, state_d;

  logic [OpWidth-1:0] op_q;
  logic               nan_q, snan_q, inf_q, zero_q;
  logic [OpWidth-1:0] res_q;
  logic               invalid_q, divzero_q, inexact_q;

  logic               is_special;
  logic [OpWidth-1:0] special_res;
  logic               special_invalid;
  logic               special_divzero;

  flog_special_mux #(
    .EXP_WIDTH  (EXP_WIDTH),
    .FRACT_WIDTH(FRACT_WIDTH)
  ) u_special_mux (
    .op_i             (op_q),
    .is_nan_i         (nan_q),
    .is_snan_i        (snan_q),
    .is_inf_i         (inf_q),
    .is_zero_i        (zero_q),
    .is_special_o     (is_special),
    .special_res_o    (special_res),
    .special_invalid_o(special_invalid),
    .special_divzero_o(special_divzero)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; core_done_i only matters while waiting on the core.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.valid_i) state_d = DECIDE;
      DECIDE:  state_d = is_special ? RESULT : START;
      START:   state_d = WAIT;
      WAIT:    if (bus.core_done_i) state_d = RESULT;
      RESULT:  if (bus.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and result/flag registers, held stable while the result is presented.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q      <= '0;
      nan_q     <= 1'b0;
      snan_q    <= 1'b0;
      inf_q     <= 1'b0;
      zero_q    <= 1'b0;
      res_q     <= '0;
      invalid_q <= 1'b0;
      divzero_q <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      if ((state_q == IDLE) && bus.valid_i) begin
        op_q   <= {bus.s_op_i, bus.exp_op_i, bus.fract_op_i};
        nan_q  <= bus.isNaN_i;
        snan_q <= bus.isSNaN_i;
        inf_q  <= bus.isInf_i;
        zero_q <= bus.isZero_i;
      end
      if ((state_q == DECIDE) && is_special) begin
        res_q     <= special_res;
        invalid_q <= special_invalid;
        divzero_q <= special_divzero;
        inexact_q <= 1'b0;
      end
      if ((state_q == WAIT) && bus.core_done_i) begin
        res_q     <= bus.core_res_i;
        invalid_q <= 1'b0;
        divzero_q <= 1'b0;
        inexact_q <= bus.core_inexact_i;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    bus.ready_o      = 1'b0;
    bus.busy_o       = 1'b1;
    bus.core_start_o = 1'b0;
    bus.valid_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        bus.busy_o  = 1'b0;
      end
      START:   bus.core_start_o = 1'b1;
      RESULT:  bus.valid_o = 1'b1;
      default: ;
    endcase
    bus.core_op_o = op_q;
    bus.res_o     = res_q;
    bus.invalid_o = invalid_q;
    bus.divzero_o = divzero_q;
    bus.inexact_o = inexact_q;
  end

endmodule

// File: tb/tb_flog_special_ctrl.sv
// Randomized self-checking bench for flog_special_ctrl with a behavioural log-special model.
module tb_flog_special_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  flog_special_ctrl_if bus ();

  flog_special_ctrl dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          special;
    logic [15:0] res;
    logic        inv;
    logic        dz;
  } model_t;

  typedef struct {
    logic [15:0] res;
    logic        inv, dz, nx;
    int          lat;
    int          starts;
    logic [15:0] start_op;
    int          done_lat;
    bit          op_stable;
    bit          hold_ok;
    bit          ready_back;
    bit          timeout;
  } txn_t;

  // IEEE-754 log of special bfloat16 operands, written straight from the field values.
  function automatic model_t model(input logic [15:0] op);
    model_t m;
    logic [7:0] e;
    logic [6:0] f;
    e = op[14:7];
    f = op[6:0];
    m.special = 1'b1;
    m.res = 16'h7FC0;
    m.inv = 1'b0;
    m.dz = 1'b0;
    if (e == 8'hFF && f != 0) m.inv = ~f[6];
    else if (e == 0) begin m.res = 16'hFF80; m.dz = 1'b1; end
    else if (op[15]) m.inv = 1'b1;
    else if (e == 8'hFF) m.res = 16'h7F80;
    else if (op == 16'h3F80) m.res = 16'h0000;
    else m.special = 1'b0;
    return m;
  endfunction

  // Operand plus the flags the upstream detector would produce for it.
  task automatic drive_op(input logic [15:0] op);
    bus.s_op_i     = op[15];
    bus.exp_op_i   = op[14:7];
    bus.fract_op_i = op[6:0];
    bus.isNaN_i    = (op[14:7] == 8'hFF) && (op[6:0] != 0);
    bus.isSNaN_i   = (op[14:7] == 8'hFF) && (op[6:0] != 0) && !op[6];
    bus.isInf_i    = (op[14:7] == 8'hFF) && (op[6:0] == 0);
    bus.isZero_i   = (op[14:0] == 0);
  endtask

  // One full transaction with a core model answering core_lat cycles after start.
  task automatic do_txn(input logic [15:0] op, input int core_lat, input logic [15:0] cres,
                        input logic cnx, input int rdy_wait, output txn_t t);
    int cnt;
    t.starts = 0; t.start_op = '0; t.done_lat = -1; t.op_stable = 1'b1;
    t.hold_ok = 1'b1; t.ready_back = 1'b0;
    @(negedge clk);
    drive_op(op);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    drive_op(16'($urandom));
    t.lat = 1;
    cnt = 0;
    while (!bus.valid_o && t.lat < 200) begin
      if (bus.core_start_o) begin
        t.starts++;
        t.start_op = bus.core_op_o;
        cnt = core_lat;
      end else if (cnt > 0) begin
        if (bus.core_op_o !== t.start_op) t.op_stable = 1'b0;
        cnt--;
        if (cnt == 0) begin
          bus.core_done_i = 1'b1;
          bus.core_res_i = cres;
          bus.core_inexact_i = cnx;
          t.done_lat = t.lat;
        end
      end
      @(negedge clk);
      t.lat++;
      bus.core_done_i = 1'b0;
      bus.core_res_i = 16'($urandom);
      bus.core_inexact_i = 1'($urandom);
    end
    t.timeout = !bus.valid_o;
    t.res = bus.res_o;
    t.inv = bus.invalid_o;
    t.dz = bus.divzero_o;
    t.nx = bus.inexact_o;
    for (int i = 0; i < rdy_wait; i++) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.res_o !== t.res ||
          {bus.invalid_o, bus.divzero_o, bus.inexact_o} !== {t.inv, t.dz, t.nx})
        t.hold_ok = 1'b0;
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    t.ready_back = (bus.ready_o === 1'b1) && (bus.valid_o === 1'b0);
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.core_start_o, bus.busy_o, bus.invalid_o,
         bus.divzero_o, bus.inexact_o} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1000000", {bus.ready_o, bus.valid_o,
               bus.core_start_o, bus.busy_o, bus.invalid_o, bus.divzero_o, bus.inexact_o});
    end
    checks++;
    if (bus.res_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_res: got %h want 0000", bus.res_o);
    end
    checks++;
    if (bus.core_op_o !== 16'h0000) begin
      errors++;
      $display("FAIL reset_core_op: got %h want 0000", bus.core_op_o);
    end
  endtask

  task automatic test_specials();
    logic [15:0] ops [10] = '{16'hFF80, 16'h0000, 16'h0001, 16'h7F81, 16'h3F80,
                              16'h7F80, 16'hFFC0, 16'h8000, 16'hC000, 16'h7FC0};
    txn_t t;
    model_t m;
    foreach (ops[i]) begin
      do_txn(ops[i], 1, 16'h1111, 1'b1, 0, t);
      m = model(ops[i]);
      checks++;
      if (t.timeout || t.res !== m.res || {t.inv, t.dz, t.nx} !== {m.inv, m.dz, 1'b0}) begin
        errors++;
        $display("FAIL special_%h: got res=%h nv/dz/nx=%b%b%b want res=%h nv/dz/nx=%b%b0",
                 ops[i], t.res, t.inv, t.dz, t.nx, m.res, m.inv, m.dz);
      end
      checks++;
      if (t.lat !== 2 || t.starts !== 0 || !t.ready_back) begin
        errors++;
        $display("FAIL special_timing_%h: got lat=%0d starts=%0d ready_back=%0d want 2 0 1",
                 ops[i], t.lat, t.starts, t.ready_back);
      end
    end
  endtask

  task automatic test_core();
    txn_t t;
    do_txn(16'h4000, 5, 16'h3F31, 1'b1, 0, t);
    checks++;
    if (t.starts !== 1 || t.start_op !== 16'h4000 || !t.op_stable) begin
      errors++;
      $display("FAIL core_start: got starts=%0d op=%h stable=%0d want 1 4000 1",
               t.starts, t.start_op, t.op_stable);
    end
    checks++;
    if (t.timeout || t.res !== 16'h3F31 || {t.inv, t.dz, t.nx} !== 3'b001) begin
      errors++;
      $display("FAIL core_result: got res=%h flags=%b%b%b want 3f31 001",
               t.res, t.inv, t.dz, t.nx);
    end
    checks++;
    if (t.lat !== 8 || t.lat !== t.done_lat + 1) begin
      errors++;
      $display("FAIL core_latency: got lat=%0d done_at=%0d want 8 and 7", t.lat, t.done_lat);
    end
  endtask

  task automatic test_backpressure();
    txn_t t;
    do_txn(16'h4120, 2, 16'h4005, 1'b0, 4, t);
    checks++;
    if (!t.hold_ok || t.res !== 16'h4005) begin
      errors++;
      $display("FAIL backpressure_hold: got hold_ok=%0d res=%h want 1 4005", t.hold_ok, t.res);
    end
    checks++;
    if (!t.ready_back) begin
      errors++;
      $display("FAIL backpressure_release: got ready_back=%0d want 1", t.ready_back);
    end
  endtask

  task automatic test_random();
    txn_t t;
    model_t m;
    logic [15:0] op, cres;
    logic cnx;
    int clat, rw, want_lat;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: op = 16'($urandom);
        1: op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
        2: op = {1'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00, 7'($urandom)};
        default: op = 16'h3F80;
      endcase
      cres = 16'($urandom);
      cnx = 1'($urandom);
      clat = $urandom_range(1, 6);
      rw = $urandom_range(0, 2);
      do_txn(op, clat, cres, cnx, rw, t);
      m = model(op);
      want_lat = m.special ? 2 : 3 + clat;
      if (!m.special) begin
        m.res = cres;
        m.inv = 1'b0;
        m.dz = 1'b0;
      end
      checks++;
      if (t.timeout || t.res !== m.res ||
          {t.inv, t.dz, t.nx} !== {m.inv, m.dz, m.special ? 1'b0 : cnx}) begin
        errors++;
        $display("FAIL random_%0d op=%h: got res=%h flags=%b%b%b want res=%h flags=%b%b%b",
                 i, op, t.res, t.inv, t.dz, t.nx, m.res, m.inv, m.dz, m.special ? 1'b0 : cnx);
      end
      checks++;
      if (t.lat !== want_lat || t.starts !== (m.special ? 0 : 1) ||
          (!m.special && t.start_op !== op) || !t.hold_ok || !t.ready_back) begin
        errors++;
        $display("FAIL random_ctrl_%0d op=%h: got lat=%0d starts=%0d hold=%0d back=%0d want lat=%0d",
                 i, op, t.lat, t.starts, t.hold_ok, t.ready_back, want_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ops [4] = '{16'h7F80, 16'h0000, 16'hBF80, 16'h3F80};
    model_t m;
    int n_in, n_out, last;
    n_in = 0; n_out = 0; last = -1;
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 40 && n_out < 4; cyc++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        m = model(ops[n_out]);
        checks++;
        if (bus.res_o !== m.res || (last >= 0 && cyc - last != 3)) begin
          errors++;
          $display("FAIL b2b_%0d: got res=%h gap=%0d want res=%h gap=3",
                   n_out, bus.res_o, cyc - last, m.res);
        end
        last = cyc;
        n_out++;
      end
      if (bus.ready_o && n_in < 4) begin
        drive_op(ops[n_in]);
        bus.valid_i = 1'b1;
        n_in++;
      end else begin
        bus.valid_i = 1'b0;
      end
    end
    @(negedge clk);
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b0;
    checks++;
    if (n_out !== 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results want 4", n_out);
    end
  endtask

  task automatic test_spurious();
    @(negedge clk);
    bus.core_done_i = 1'b1;
    bus.core_res_i = 16'hABCD;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    checks++;
    if ({bus.ready_o, bus.busy_o, bus.valid_o} !== 3'b100) begin
      errors++;
      $display("FAIL spurious_idle: got rdy/busy/vld=%b want 100",
               {bus.ready_o, bus.busy_o, bus.valid_o});
    end
    drive_op(16'h4000);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.core_done_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.core_start_o, bus.valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL spurious_decide: got start/vld=%b want 10", {bus.core_start_o, bus.valid_o});
    end
    @(negedge clk);
    bus.core_done_i = 1'b0;
    checks++;
    if ({bus.core_start_o, bus.valid_o, bus.busy_o} !== 3'b001) begin
      errors++;
      $display("FAIL spurious_start: got start/vld/busy=%b want 001",
               {bus.core_start_o, bus.valid_o, bus.busy_o});
    end
    @(negedge clk);
    bus.core_done_i = 1'b1;
    bus.core_res_i = 16'h3E00;
    bus.core_inexact_i = 1'b0;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.res_o !== 16'h3E00) begin
      errors++;
      $display("FAIL spurious_done: got vld=%b res=%h want 1 3e00", bus.valid_o, bus.res_o);
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    txn_t t;
    int k;
    drive_op(16'h4100);
    bus.valid_i = 1'b1;
    @(negedge clk);
    bus.valid_i = 1'b0;
    k = 0;
    while (!bus.core_start_o && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (bus.core_start_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_start: got start=%b want 1", bus.core_start_o);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.ready_o, bus.valid_o, bus.busy_o, bus.core_start_o} !== 4'b1000 ||
        bus.res_o !== 16'h0000 || bus.core_op_o !== 16'h0000) begin
      errors++;
      $display("FAIL areset_outputs: got rdy/vld/busy/start=%b res=%h op=%h want 1000 0000 0000",
               {bus.ready_o, bus.valid_o, bus.busy_o, bus.core_start_o}, bus.res_o,
               bus.core_op_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.core_done_i = 1'b1;
    bus.core_res_i = 16'h1234;
    @(negedge clk);
    bus.core_done_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL areset_late_done: got vld=%b rdy=%b busy=%b want 0 1 0",
               bus.valid_o, bus.ready_o, bus.busy_o);
    end
    do_txn(16'h7F80, 1, 16'h0101, 1'b1, 0, t);
    checks++;
    if (t.timeout || t.res !== 16'h7F80 || {t.inv, t.dz, t.nx} !== 3'b000 || t.lat !== 2) begin
      errors++;
      $display("FAIL areset_next_op: got res=%h flags=%b%b%b lat=%0d want 7f80 000 2",
               t.res, t.inv, t.dz, t.nx, t.lat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.core_done_i = 1'b0;
    bus.core_res_i = '0;
    bus.core_inexact_i = 1'b0;
    drive_op(16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_specials();
    test_core();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_spurious();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/flog_special_ctrl.md
Name: flog_special_ctrl

Overview:
Control stage directly downstream of the bfloat16 special-case detector in the FLOG (logarithm) datapath. It accepts one operand plus its classification flags over a valid/ready handshake. Special operands resolve to an IEEE-754 log result without engaging the arithmetic core; normal operands are dispatched to the iterative log core through a start/done handshake. It then presents exactly one result, with exception flags, to the downstream consumer.

Parameters:
EXP_WIDTH, 8, exponent field width
FRACT_WIDTH, 7, stored mantissa width (operand/result width = 1+EXP_WIDTH+FRACT_WIDTH = 16)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
valid_i  in  1  upstream operand valid
ready_o  out  1  block can accept operand
s_op_i  in  1  operand sign
exp_op_i  in  EXP_WIDTH  operand exponent
fract_op_i  in  FRACT_WIDTH  operand mantissa
isNaN_i, isSNaN_i, isInf_i, isZero_i  in  1 each  classification flags from detector, same cycle as operand
core_start_o  out  1  one-cycle start pulse to log core
core_op_o  out  16  operand to core {s,exp,fract}, stable from start until done
core_done_i  in  1  core result valid (single-cycle pulse)
core_res_i  in  16  core result, valid with core_done_i
core_inexact_i  in  1  core inexact flag, valid with core_done_i
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
res_o  out  16  result {s,exp,fract}
invalid_o  out  1  NV flag, valid with valid_o
divzero_o  out  1  DZ flag, valid with valid_o
inexact_o  out  1  NX flag, valid with valid_o
busy_o  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset (asynchronous, any state, including mid-core-operation): state=IDLE. ready_o=1; valid_o, core_start_o, busy_o, invalid_o, divzero_o, inexact_o=0. res_o=16'h0000 and core_op_o=16'h0000. An in-flight core_done_i after reset is ignored.
- FSM states: IDLE, DECIDE, START, WAIT, RESULT.
- IDLE: ready_o=1. valid_i&ready_o at an edge registers the operand and flags, then goes to DECIDE. ready_o=0 in all other states; there is no pipelining and at most one operand is in flight.
- DECIDE: one cycle. The special-case priority below is evaluated on the registered values:
  1. isNaN: res=QNAN 16'h7FC0, invalid=isSNaN.
  2. zero or subnormal (exp==0; subnormals flush to zero, sign ignored): res=MINUS_INF 16'hFF80, divzero=1.
  3. s=1 (negative finite or -inf): res=QNAN, invalid=1.
  4. +inf: res=PLUS_INF 16'h7F80.
  5. exactly +1.0 (16'h3F80): res=PLUS_ZERO 16'h0000, all flags 0.
  6. otherwise: go to START.
  A special case goes to RESULT with the result and flags registered.
- START: core_start_o=1 for exactly this cycle; core_op_o holds the operand. Next state is WAIT.
- WAIT: waits indefinitely for core_done_i. On core_done_i, captures core_res_i and core_inexact_i into res_o/inexact_o (invalid=divzero=0) and goes to RESULT. core_done_i is ignored in every state except WAIT.
- RESULT: valid_o=1. res_o and the flags are held stable until ready_i. valid_o&ready_i at an edge goes to IDLE, and valid_o drops the next cycle. Same-cycle accept of a new operand is not supported; ready_o rises the cycle after the result handshake.
- Latency, measured from the input handshake edge to the first cycle with valid_o=1:
  - special path: 2 cycles.
  - core path: 3 cycles plus the number of WAIT cycles.
- Back-to-back throughput on the special path: one result per 3 cycles when ready_i=1.

Decomposition:
- Package flog_pkg holds:
  - constants QNAN, PLUS_INF, MINUS_INF, PLUS_ZERO, ONE (16'h3F80);
  - the widths;
  - typedef enum flog_ctrl_state_t {IDLE, DECIDE, START, WAIT, RESULT}.
- One combinational sub-module, flog_special_mux, implements the DECIDE priority table. It takes the registered operand and flags and outputs is_special, special_res, special_invalid and special_divzero. It is unit-testable standalone.

Test Plan:
- Input 16'hFF80 (-inf, isInf=1): res_o=16'h7FC0, invalid_o=1, valid_o 2 cycles after the accept, core_start_o never pulses.
- Input 16'h0000, then 16'h0001 (subnormal): both give res_o=16'hFF80, divzero_o=1. Input 16'h7F81 (sNaN): res_o=16'h7FC0, invalid_o=1. Input 16'h3F80: res_o=16'h0000, flags 0.
- Input 16'h4000 (2.0): one core_start_o pulse with core_op_o=16'h4000. Core model returns 16'h3F31 with inexact=1 after 5 cycles. Then res_o=16'h3F31, inexact_o=1, valid_o exactly 1 cycle after core_done_i.
- Hold ready_i=0 for 4 cycles in RESULT: valid_o, res_o and flags stay stable and ready_o stays 0. On ready_i=1, the FSM returns to IDLE and ready_o=1 the next cycle.
- Spurious core_done_i while in IDLE, DECIDE and START: no state change and no valid_o.
- Assert rst_n_i low asynchronously during WAIT: outputs reach their reset values immediately. After release, a late core_done_i produces no valid_o, and the next operand (16'h7F80) returns 16'h7F80.
